uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first; the far end of the `uart_txd` link that `top_level` drives.
- Used in the bench/loopback harness to decode bytes from `uart_txd`.
- Used on-chip for host commands into the stereo pipeline.
- Delivers each byte on a valid/ready output with framing-error and overrun reporting.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CYCLES_PER_BIT (localparam), CLK_HZ/BAUD (integer division), clocks per bit; must be >= 4 (elaboration assertion).
- HALF_BIT (localparam), CYCLES_PER_BIT/2, offset to mid-bit.

Ports:
- clk_in  input  1  system clock (100 MHz in top_level).
- rst_in_n  input  1  reset, asynchronous assert, active-low.
- rxd_in  input  1  asynchronous serial line; idle high.
- data_out  output  8  received byte.
- valid_out  output  1  data_out holds an unconsumed byte.
- ready_in  input  1  consumer accepts data_out when valid_out && ready_in.
- frame_err_out  output  1  one-cycle pulse: stop bit sampled low.
- overrun_out  output  1  one-cycle pulse: a new byte was dropped because the previous one was unconsumed.

Behaviour:
- Reset (async, rst_in_n=0):
  - data_out=8'h00, valid_out=0, frame_err_out=0, overrun_out=0.
  - Synchronizer flops preset to 1; FSM=IDLE; counters 0.
  - Reset mid-frame discards the partial byte.
  - After release the FSM waits in IDLE for a falling edge.
- rxd_in passes through a 2-flop synchronizer (rxd_s); a pin edge reaches rxd_s 2 cycles later.
- IDLE: on rxd_s==0 -> START, bit counter cleared.
- START: at count HALF_BIT-1 sample rxd_s.
  - 0 -> DATA, count=0, bit_idx=0.
  - 1 -> IDLE (glitch rejected, nothing reported).
- DATA: at count CYCLES_PER_BIT-1 sample rxd_s and shift into shreg MSB (shreg <= {rxd_s, shreg[7:1]}).
  - After bit_idx==7 -> STOP; otherwise bit_idx++.
  - Samples fall at mid-bit ±1 cycle.
- STOP: at count CYCLES_PER_BIT-1 sample rxd_s.
  - 1 -> deliver shreg, -> IDLE.
  - 0 -> frame_err_out pulses next cycle, byte dropped, -> WAIT_HIGH.
- WAIT_HIGH: stays until rxd_s==1, then -> IDLE. A held-low break produces exactly one frame error, not repeated frames.
- Delivery (registered; outputs update the cycle after the stop sample):
  - valid_out==0, or handshake (valid_out && ready_in) in the same cycle: data_out<=shreg, valid_out<=1, no overrun.
  - valid_out==1 && ready_in==0: data_out unchanged, valid_out stays 1, overrun_out pulses one cycle, new byte discarded.
- Handshake with no delivery: valid_out<=0 next cycle; data_out keeps its last value.
- data_out is stable while valid_out==1 && ready_in==0.
- Back-to-back frames with no idle gap are received: IDLE is entered mid-stop-bit, so the next start edge is seen.
- Latency: start-bit falling edge on the pin -> valid_out high = 2 + HALF_BIT + 9*CYCLES_PER_BIT + 1 cycles (±1 for edge alignment).
- Counters sized $clog2(CYCLES_PER_BIT); bit_idx 3 bits. No wrap beyond CYCLES_PER_BIT-1 (cleared on each terminal count).

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_rx_state_t.
  - Function cycles_per_bit(clk_hz, baud).
  - Constants DATA_BITS=8, IDLE_LEVEL=1'b1.
  - The planned uart_tx reuses this package.
- One sub-module: synchronizer_2ff (parameter RESET_VAL, async active-low reset), instanced on rxd_in.
- Baud counter and FSM stay inline.

Test Plan (CLK_HZ=100_000_000, BAUD=10_000_000 -> CYCLES_PER_BIT=10; ready_in=1 unless stated):
- Send 8'hA5 -> one valid_out cycle with data_out=8'hA5 within 98±2 cycles of the start edge; frame_err_out and overrun_out stay 0.
- Back-to-back 8'h00 then 8'hFF, no idle gap -> two valid_out pulses 100 cycles apart, data 8'h00 then 8'hFF.
- 3-cycle low glitch on idle line -> no valid_out, no frame_err_out, FSM back in IDLE; a following 8'h5A still decodes.
- 8'h3C with stop bit 0, line held low 50 cycles, then high -> exactly one frame_err_out pulse, no valid_out; next frame 8'h81 decodes correctly.
- ready_in=0; send 8'h11 then 8'h22 -> data_out=8'h11, valid_out held, one overrun_out pulse after the 8'h22 stop bit. Then ready_in=1 -> valid_out drops next cycle; data_out still 8'h11.
- Assert rst_in_n=0 for 3 cycles mid-DATA of 8'hC3 -> outputs reset immediately, no valid_out for the aborted frame; next full frame 8'h7E decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants; the receiver uses them now and the planned transmitter will too.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/synchronizer_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages preset to RESET_VAL.
module synchronizer_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic d_in,
  output logic q_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a valid/ready byte output plus framing-error and overrun pulses.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for rxd_s to go low
// START     | counting to mid start bit; a high sample there is a glitch
// DATA      | one sample per bit period, shifted in LSB first
// STOP      | sampling the stop bit; high delivers the byte, low is a frame error
// WAIT_HIGH | after a frame error, hold off until the line returns high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       rxd_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       frame_err_out,
  output logic       overrun_out
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  if (CYCLES_PER_BIT < 4) begin : g_bad_rate
    $error("uart_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic rxd_s;

  synchronizer_2ff #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_rxd_sync (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .d_in     (rxd_in),
    .q_out    (rxd_s)
  );

  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             deliver;
  logic             cnt_tc_half;
  logic             cnt_tc_bit;

  assign cnt_tc_half = (cnt_q == HALF_TC);
  assign cnt_tc_bit  = (cnt_q == BIT_TC);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxd_s == 1'b0) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_tc_half) begin
          cnt_d = '0;
          if (rxd_s == 1'b0) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_tc_bit) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[7:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_tc_bit) begin
          cnt_d = '0;
          if (rxd_s == 1'b1) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s == 1'b1) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A byte landing while the previous one is still held (and not being taken) is dropped.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (deliver) begin
      if (!valid_q || ready_in) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign frame_err_out = frame_err_q;
  assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: normal, back-to-back, glitch, framing, overrun and reset cases.
module tb_uart_rx;

  logic       clk_in;
  logic       rst_in_n;
  logic       rxd_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       frame_err_out;
  logic       overrun_out;

  uart_rx #(
    .CLK_HZ (100_000_000),
    .BAUD   (10_000_000)
  ) dut (
    .clk_in        (clk_in),
    .rst_in_n      (rst_in_n),
    .rxd_in        (rxd_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .frame_err_out (frame_err_out),
    .overrun_out   (overrun_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] hs_data[$];
  int         hs_cyc[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         t_start = 0;

  always @(negedge clk_in) begin
    if (valid_out && ready_in) begin
      hs_data.push_back(data_out);
      hs_cyc.push_back(cyc);
    end
    if (frame_err_out) fe_cnt++;
    if (overrun_out) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd_in = b;
    tick(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len);
    t_start = cyc + 1;
    drive_bit(1'b0, 10);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 10);
    drive_bit(stop_bit, stop_len);
    rxd_in = 1'b1;
  endtask

  task automatic clear_log();
    hs_data.delete();
    hs_cyc.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  int lat;

  initial begin
    rst_in_n = 1'b0;
    rxd_in   = 1'b1;
    ready_in = 1'b1;
    tick(5);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_ferr", frame_err_out, 1'b0);
    chk("rst_ovr", overrun_out, 1'b0);
    rst_in_n = 1'b1;
    tick(10);

    // single byte with latency window
    clear_log();
    send_byte(8'hA5, 1'b1, 10);
    tick(20);
    chk("a5_count", hs_data.size(), 1);
    if (hs_data.size() >= 1) begin
      chk("a5_data", hs_data[0], 8'hA5);
      lat = hs_cyc[0] - t_start;
      chk("a5_latency_96_100", (lat >= 96 && lat <= 100), 1'b1);
    end
    chk("a5_ferr", fe_cnt, 0);
    chk("a5_ovr", ov_cnt, 0);

    // back-to-back without idle gap
    clear_log();
    send_byte(8'h00, 1'b1, 10);
    send_byte(8'hFF, 1'b1, 10);
    tick(20);
    chk("b2b_count", hs_data.size(), 2);
    if (hs_data.size() >= 2) begin
      chk("b2b_data0", hs_data[0], 8'h00);
      chk("b2b_data1", hs_data[1], 8'hFF);
      chk("b2b_spacing", hs_cyc[1] - hs_cyc[0], 100);
    end

    // short low glitch on the idle line
    clear_log();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    chk("glitch_count", hs_data.size(), 0);
    chk("glitch_ferr", fe_cnt, 0);
    send_byte(8'h5A, 1'b1, 10);
    tick(20);
    chk("after_glitch_count", hs_data.size(), 1);
    if (hs_data.size() >= 1) chk("after_glitch_data", hs_data[0], 8'h5A);

    // stop bit low, line held low (break)
    clear_log();
    send_byte(8'h3C, 1'b0, 50);
    tick(20);
    chk("brk_ferr_pulses", fe_cnt, 1);
    chk("brk_count", hs_data.size(), 0);
    send_byte(8'h81, 1'b1, 10);
    tick(20);
    chk("after_brk_count", hs_data.size(), 1);
    if (hs_data.size() >= 1) chk("after_brk_data", hs_data[0], 8'h81);
    chk("after_brk_ferr", fe_cnt, 1);

    // overrun while consumer stalled
    clear_log();
    ready_in = 1'b0;
    send_byte(8'h11, 1'b1, 10);
    chk("stall_valid1", valid_out, 1'b1);
    send_byte(8'h22, 1'b1, 10);
    tick(20);
    chk("ovr_data", data_out, 8'h11);
    chk("ovr_valid", valid_out, 1'b1);
    chk("ovr_pulses", ov_cnt, 1);
    chk("ovr_ferr", fe_cnt, 0);
    ready_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("ovr_drain_valid", valid_out, 1'b0);
    chk("ovr_drain_data", data_out, 8'h11);
    chk("ovr_drain_count", hs_data.size(), 1);
    tick(5);

    // reset in the middle of a data phase
    clear_log();
    t_start = cyc + 1;
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 10);
    drive_bit(1'b1, 10);
    drive_bit(1'b0, 5);
    rst_in_n = 1'b0;
    #1;
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_valid", valid_out, 1'b0);
    rxd_in = 1'b1;
    tick(3);
    rst_in_n = 1'b1;
    tick(30);
    chk("midrst_count", hs_data.size(), 0);
    send_byte(8'h7E, 1'b1, 10);
    tick(20);
    chk("after_rst_count", hs_data.size(), 1);
    if (hs_data.size() >= 1) chk("after_rst_data", hs_data[0], 8'h7E);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
